// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard
//   Forwarding and interlock controller for the integer pipeline. Tracks
//   in-flight register writers from EX onward. For the instruction in ID it
//   either raises a load-use / multi-cycle stall, or registers one
//   forward-select per source operand for use in EX on the next cycle.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   id_valid     : valid instruction in ID
//   id_rs        : NUM_SRC source addresses, operand i at [i*AW +: AW]
//   id_rd        : destination register of the ID instruction
//   id_reg_write : ID instruction writes id_rd
//   id_lat       : slot at which the result becomes forwardable (1..DEPTH-1)
//   hold         : global pipeline freeze
//   flush        : kill the ID instruction
//   stall        : combinational, ID must not advance
//   ex_valid     : EX holds a valid tracked instruction
//   ex_fwd_sel   : per-operand forward select for EX (0 = register file)
//   stall_count  : saturating count of stall cycles
module forwarding_scoreboard #(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned AW      = 5,
  parameter int unsigned LAT_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid,
  input  logic [NUM_SRC*AW-1:0]             id_rs,
  input  logic [AW-1:0]                     id_rd,
  input  logic                              id_reg_write,
  input  logic [LAT_W-1:0]                  id_lat,
  input  logic                              hold,
  input  logic                              flush,
  output logic                              stall,
  output logic                              ex_valid,
  output logic [NUM_SRC*$clog2(DEPTH)-1:0]  ex_fwd_sel,
  output logic [CNT_W-1:0]                  stall_count
);

  localparam int unsigned SEL_W = $clog2(DEPTH);
  // The oldest slot (DEPTH-1) is never searched and never observable, so
  // only slots 0..DEPTH-2 are stored; an entry simply drops off the end.
  localparam int unsigned NSLOT = DEPTH - 1;

  typedef enum logic [1:0] {
    ACT_FREEZE,
    ACT_BUBBLE,
    ACT_ISSUE
  } action_e;

  logic [NSLOT-1:0]                 vld_q, vld_d;
  logic [NSLOT-1:0]                 wr_q, wr_d;
  logic [NSLOT-1:0][AW-1:0]         rd_q, rd_d;
  logic [NSLOT-1:0][SEL_W-1:0]      lat_q, lat_d;
  logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_q, fwd_d;
  logic                             ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  logic [NUM_SRC-1:0][SEL_W-1:0]    sel_c;
  logic [NUM_SRC-1:0]               haz_c;
  logic [SEL_W-1:0]                 lat_in;
  action_e                          act;

  // Per-operand match. Slots are scanned oldest to youngest so the youngest
  // matching writer overwrites any older result. k is slot index + 1.
  always_comb begin
    sel_c = '0;
    haz_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = NSLOT; k > 0; k--) begin
        if (vld_q[k-1] && wr_q[k-1] && (rd_q[k-1] != '0) &&
            (rd_q[k-1] == id_rs[i*AW +: AW])) begin
          if (k >= 32'(lat_q[k-1])) begin
            sel_c[i] = SEL_W'(k);
            haz_c[i] = 1'b0;
          end else begin
            sel_c[i] = '0;
            haz_c[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stall = id_valid & ~flush & (|haz_c);

  // Clamp latency into the legal 1..DEPTH-1 range.
  always_comb begin
    if (id_lat == '0) begin
      lat_in = SEL_W'(1);
    end else if (32'(id_lat) >= DEPTH) begin
      lat_in = SEL_W'(DEPTH - 1);
    end else begin
      lat_in = SEL_W'(id_lat);
    end
  end

  always_comb begin
    act = ACT_ISSUE;
    if (hold) begin
      act = ACT_FREEZE;
    end else if (flush || stall) begin
      act = ACT_BUBBLE;
    end
  end

  always_comb begin
    vld_d      = vld_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    lat_d      = lat_q;
    fwd_d      = fwd_q;
    ex_valid_d = ex_valid_q;
    cnt_d      = cnt_q;
    if (act != ACT_FREEZE) begin
      for (int unsigned j = NSLOT - 1; j > 0; j--) begin
        vld_d[j] = vld_q[j-1];
        wr_d[j]  = wr_q[j-1];
        rd_d[j]  = rd_q[j-1];
        lat_d[j] = lat_q[j-1];
      end
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (act == ACT_BUBBLE) begin
        vld_d[0]   = 1'b0;
        wr_d[0]    = 1'b0;
        rd_d[0]    = '0;
        lat_d[0]   = '0;
        fwd_d      = '0;
        ex_valid_d = 1'b0;
      end else begin
        vld_d[0]   = id_valid;
        wr_d[0]    = id_reg_write & id_valid;
        rd_d[0]    = id_rd;
        lat_d[0]   = lat_in;
        fwd_d      = sel_c;
        ex_valid_d = id_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      lat_q      <= '0;
      fwd_q      <= '0;
      ex_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vld_q      <= vld_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      lat_q      <= lat_d;
      fwd_q      <= fwd_d;
      ex_valid_q <= ex_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_fwd_sel  = fwd_q;
  assign ex_valid    = ex_valid_q;
  assign stall_count = cnt_q;

endmodule
